// File: rtl/ram_access_sequencer_if.sv
// rtl/ram_access_sequencer_if.sv - receive, RAM and transmit signals of the RAM access sequencer
interface ram_access_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  // master is the sequencer's side; slave is receiver, RAM and transmitter.
  modport master (
    input  rx_valid, rx_data, ram_rdata, tx_ready,
    output rx_ready, ram_addr, ram_we, ram_wdata, tx_valid, tx_data
  );

  modport slave (
    output rx_valid, rx_data, ram_rdata, tx_ready,
    input  rx_ready, ram_addr, ram_we, ram_wdata, tx_valid, tx_data
  );
endinterface

// File: rtl/ram_access_sequencer.sv
// rtl/ram_access_sequencer.sv - buffers received words in RAM and plays them back to the transmitter
module ram_access_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int SEND_GAP = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_access_sequencer_if.master bus,
  input  logic                  send,
  input  logic                  clear,
  output logic                  busy,
  output logic [ADDR_W:0]       word_count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_RD,
    ST_SEND_WAIT,
    ST_SEND_OUT,
    ST_SEND_GAP
  } state_t;

  localparam int GAP_W = (SEND_GAP > 1) ? $clog2(SEND_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((SEND_GAP > 0) ? SEND_GAP - 1 : 0);
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t           state;
  state_t           state_next;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  rd_next;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;

  assign full          = (word_count == CAPACITY);
  assign empty         = (word_count == '0);
  assign bus.rx_ready  = (state == ST_IDLE) && !full && !clear;
  assign accept        = bus.rx_valid && bus.rx_ready;
  assign rd_next       = rd_ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      // A word accepted in this same cycle already counts toward a non-empty buffer.
      ST_IDLE:      if (send && (!empty || accept)) state_next = ST_SEND_RD;
      ST_SEND_RD:   state_next = ST_SEND_WAIT;
      ST_SEND_WAIT: state_next = ST_SEND_OUT;
      ST_SEND_OUT: begin
        if (bus.tx_ready) begin
          if (rd_next == word_count) state_next = ST_IDLE;
          else if (SEND_GAP == 0)    state_next = ST_SEND_RD;
          else                       state_next = ST_SEND_GAP;
        end
      end
      ST_SEND_GAP:  if (gap_cnt == GAP_LAST) state_next = ST_SEND_RD;
      default:      state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_comb begin
    bus.ram_addr  = rd_ptr[ADDR_W-1:0];
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.tx_valid  = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy          = 1'b0;
        bus.ram_addr  = word_count[ADDR_W-1:0];
        bus.ram_we    = accept;
        bus.ram_wdata = accept ? bus.rx_data : '0;
      end
      ST_SEND_OUT: bus.tx_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count  <= '0;
      rd_ptr      <= '0;
      gap_cnt     <= '0;
      overflow    <= 1'b0;
      bus.tx_data <= '0;
    end else if (clear) begin
      word_count <= '0;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) word_count <= word_count + 1'b1;
      if ((state == ST_IDLE) && bus.rx_valid && full) overflow <= 1'b1;
      if (state == ST_IDLE) rd_ptr <= '0;
      if (state == ST_SEND_WAIT) bus.tx_data <= bus.ram_rdata;
      if ((state == ST_SEND_OUT) && bus.tx_ready) rd_ptr <= rd_next;
      gap_cnt <= (state == ST_SEND_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end
endmodule
